// File: rtl/waveform_sequencer_if.sv
// rtl/waveform_sequencer_if.sv - control/status bundle between playlist sequencer and its host/generator
interface waveform_sequencer_if #(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 8,
    parameter int DIV_W   = 8
);
    localparam int IW = $clog2(DEPTH);

    logic               cfg_we;
    logic [IW-1:0]      cfg_addr;
    logic [2:0]         cfg_sel;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_last;
    logic [DIV_W-1:0]   divisor;
    logic               loop_en;
    logic               start;
    logic               stop;
    logic               period_done;
    logic [2:0]         sel;
    logic               tick;
    logic               busy;
    logic               done;
    logic [IW-1:0]      idx;

    modport master (
        output cfg_we, cfg_addr, cfg_sel, cfg_dwell, cfg_last,
        output divisor, loop_en, start, stop, period_done,
        input  sel, tick, busy, done, idx
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_sel, cfg_dwell, cfg_last,
        input  divisor, loop_en, start, stop, period_done,
        output sel, tick, busy, done, idx
    );
endinterface

// File: rtl/waveform_sequencer.sv
// rtl/waveform_sequencer.sv - playlist controller stepping (sel, dwell) entries for the waveform generator
module waveform_sequencer #(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 8,
    parameter int DIV_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    waveform_sequencer_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state;
    logic [2:0]         tbl_sel   [DEPTH];
    logic [DWELL_W-1:0] tbl_dwell [DEPTH];
    logic               tbl_last  [DEPTH];

    logic [2:0]         sel_q;
    logic               tick_q;
    logic               busy_q;
    logic               done_q;
    logic [IW-1:0]      idx_q;
    logic [DIV_W-1:0]   presc;
    logic [DIV_W-1:0]   presc_nxt;
    logic [DWELL_W-1:0] remaining;
    logic [DIV_W-1:0]   div_q;
    logic               loop_q;
    logic               end_of_list;

    assign bus.sel  = sel_q;
    assign bus.tick = tick_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.idx  = idx_q;

    // Prescaler wraps at the latched divisor; tick is registered one step ahead so it lines up with presc==divisor.
    always_comb begin
        presc_nxt   = (presc == div_q) ? '0 : presc + 1'b1;
        end_of_list = tbl_last[idx_q] || (idx_q == IW'(DEPTH - 1));
    end

    // Playlist table: writable only while playback is not active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_sel[i]   <= '0;
                tbl_dwell[i] <= '0;
                tbl_last[i]  <= 1'b0;
            end
        end else if (bus.cfg_we && !busy_q) begin
            tbl_sel[bus.cfg_addr]   <= bus.cfg_sel;
            tbl_dwell[bus.cfg_addr] <= bus.cfg_dwell;
            tbl_last[bus.cfg_addr]  <= bus.cfg_last;
        end
    end

    // Sequencer FSM: stop beats start, start beats everything else, then per-state behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            sel_q     <= '0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            idx_q     <= '0;
            presc     <= '0;
            remaining <= '0;
            div_q     <= '0;
            loop_q    <= 1'b0;
        end else if (bus.stop) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            tick_q <= 1'b0;
        end else if (bus.start) begin
            div_q  <= bus.divisor;
            loop_q <= bus.loop_en;
            idx_q  <= '0;
            state  <= S_LOAD;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    sel_q     <= tbl_sel[idx_q];
                    remaining <= (tbl_dwell[idx_q] == '0) ? DWELL_W'(1) : tbl_dwell[idx_q];
                    presc     <= '0;
                    tick_q    <= (div_q == '0);
                    state     <= S_RUN;
                end
                S_RUN: begin
                    presc  <= presc_nxt;
                    tick_q <= (presc_nxt == div_q);
                    if (bus.period_done) begin
                        if (remaining > DWELL_W'(1)) begin
                            remaining <= remaining - 1'b1;
                        end else begin
                            tick_q <= 1'b0;
                            if (!end_of_list) begin
                                idx_q <= idx_q + 1'b1;
                                state <= S_LOAD;
                            end else if (loop_q) begin
                                idx_q <= '0;
                                state <= S_LOAD;
                            end else begin
                                state  <= S_DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_waveform_sequencer.sv
// tb/tb_waveform_sequencer.sv - self-checking bench for waveform_sequencer
module tb_waveform_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    waveform_sequencer_if #(.DEPTH(8), .DWELL_W(8), .DIV_W(8)) bus ();

    waveform_sequencer #(.DEPTH(8), .DWELL_W(8), .DIV_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0] sel;
        logic [2:0] idx;
    } exp_t;

    exp_t       sb[$];
    exp_t       got;
    exp_t       want;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [2:0] m_sel   [8];
    int         m_dwell [8];
    bit         m_last  [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_sel[i] = 3'd0; m_dwell[i] = 0; m_last[i] = 1'b0;
        end
    endtask

    task automatic write_entry(input int a, input int s, input int d, input bit l);
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'(a); bus.cfg_sel = 3'(s);
        bus.cfg_dwell = 8'(d); bus.cfg_last = l;
        step();
        bus.cfg_we = 1'b0;
        if (!bus.busy) begin
            m_sel[a] = 3'(s); m_dwell[a] = d; m_last[a] = l;
        end
    endtask

    task automatic do_start(input int div, input bit lp);
        bus.divisor = 8'(div); bus.loop_en = lp; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic pop_compare(input string name);
        n_tests++;
        got = {bus.sel, bus.idx};
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got sel=%0d idx=%0d", name, got.sel, got.idx);
        end else begin
            want = sb.pop_front();
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got sel=%0d idx=%0d, expected sel=%0d idx=%0d",
                         name, got.sel, got.idx, want.sel, want.idx);
            end
        end
    endtask

    task automatic test_reset();
        step();
        n_tests++;
        if ({bus.sel, bus.tick, bus.busy, bus.done, bus.idx} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_state: got sel=%0d tick=%b busy=%b done=%b idx=%0d, expected all 0",
                     bus.sel, bus.tick, bus.busy, bus.done, bus.idx);
        end
        rst = 1'b1;
        step();
        write_entry(0, 5, 3, 1'b0);
        do_start(0, 1'b0);
        step();
        step();
        n_tests++;
        if (bus.sel !== 3'd5 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_run: got sel=%0d busy=%b, expected sel=5 busy=1", bus.sel, bus.busy);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({bus.sel, bus.tick, bus.busy, bus.idx} !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: got sel=%0d tick=%b busy=%b idx=%0d, expected all 0",
                     bus.sel, bus.tick, bus.busy, bus.idx);
        end
        model_clear();
        step();
        rst = 1'b1;
        step();
        do_start(0, 1'b0);
        step();
        sb.push_back('{sel: m_sel[0], idx: 3'd0});
        pop_compare("empty_table_first_entry");
        bus.period_done = 1'b1;
        step();
        bus.period_done = 1'b0;
        n_tests++;
        if (bus.idx !== 3'd1 || bus.busy !== 1'b1 || bus.tick !== 1'b0) begin
            n_fail++;
            $display("FAIL dwell0_as_1: got idx=%0d busy=%b tick=%b, expected idx=1 busy=1 tick=0",
                     bus.idx, bus.busy, bus.tick);
        end
        do_stop();
    endtask

    task automatic test_basic();
        write_entry(0, 1, 2, 1'b0);
        write_entry(1, 3, 1, 1'b1);
        do_start(3, 1'b0);
        n_tests++;
        if (bus.busy !== 1'b1 || bus.tick !== 1'b0) begin
            n_fail++;
            $display("FAIL load_cycle: got busy=%b tick=%b, expected busy=1 tick=0", bus.busy, bus.tick);
        end
        step();
        sb.push_back('{sel: 3'd1, idx: 3'd0});
        pop_compare("basic_first_run");
        for (int k = 1; k <= 8; k++) begin
            n_tests++;
            if (bus.tick !== (k % 4 == 0)) begin
                n_fail++;
                $display("FAIL tick_div3 cycle %0d: got %b, expected %b", k, bus.tick, (k % 4 == 0));
            end
            step();
        end
        bus.period_done = 1'b1;
        step();
        sb.push_back('{sel: 3'd3, idx: 3'd1});
        step();
        bus.period_done = 1'b0;
        n_tests++;
        if (bus.idx !== 3'd1 || bus.tick !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_load2: got idx=%0d tick=%b busy=%b, expected idx=1 tick=0 busy=1",
                     bus.idx, bus.tick, bus.busy);
        end
        step();
        pop_compare("basic_entry1");
        bus.period_done = 1'b1;
        step();
        bus.period_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.tick !== 1'b0 || bus.sel !== 3'd3) begin
                n_fail++;
                $display("FAIL basic_done cycle %0d: got done=%b busy=%b tick=%b sel=%0d, expected 1 0 0 3",
                         k, bus.done, bus.busy, bus.tick, bus.sel);
            end
            step();
        end
    endtask

    task automatic test_loop();
        int cur;
        int nxt;
        int d;
        cur = 0;
        do_start(1, 1'b1);
        step();
        sb.push_back('{sel: m_sel[0], idx: 3'd0});
        pop_compare("loop_first");
        for (int adv = 0; adv < 6; adv++) begin
            d = (m_dwell[cur] == 0) ? 1 : m_dwell[cur];
            for (int p = 0; p < d; p++) begin
                bus.period_done = 1'b1;
                if (p == d - 1) begin
                    nxt = (m_last[cur] || cur == 7) ? 0 : cur + 1;
                    sb.push_back('{sel: m_sel[nxt], idx: 3'(nxt)});
                end
                step();
                bus.period_done = 1'b0;
            end
            n_tests++;
            if (bus.tick !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL loop_load %0d: got tick=%b busy=%b done=%b, expected 0 1 0",
                         adv, bus.tick, bus.busy, bus.done);
            end
            step();
            pop_compare("loop_advance");
            cur = nxt;
        end
        do_stop();
    endtask

    task automatic test_div0();
        do_start(0, 1'b0);
        n_tests++;
        if (bus.tick !== 1'b0) begin
            n_fail++;
            $display("FAIL div0_load: got tick=%b, expected 0", bus.tick);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            n_tests++;
            if (bus.tick !== 1'b1) begin
                n_fail++;
                $display("FAIL div0_run cycle %0d: got tick=%b, expected 1", k, bus.tick);
            end
        end
        bus.period_done = 1'b1;
        step();
        step();
        bus.period_done = 1'b0;
        n_tests++;
        if (bus.tick !== 1'b0 || bus.idx !== 3'd1) begin
            n_fail++;
            $display("FAIL div0_reload: got tick=%b idx=%0d, expected tick=0 idx=1", bus.tick, bus.idx);
        end
        step();
        n_tests++;
        if (bus.tick !== 1'b1) begin
            n_fail++;
            $display("FAIL div0_after_load: got tick=%b, expected 1", bus.tick);
        end
        do_stop();
    endtask

    task automatic test_stop_priority();
        do_start(2, 1'b0);
        step();
        write_entry(0, 7, 5, 1'b1);
        bus.period_done = 1'b1;
        step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        bus.period_done = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tick !== 1'b0 ||
            bus.idx !== 3'd0 || bus.sel !== m_sel[0]) begin
            n_fail++;
            $display("FAIL stop_priority: got busy=%b done=%b tick=%b idx=%0d sel=%0d, expected 0 0 0 0 %0d",
                     bus.busy, bus.done, bus.tick, bus.idx, bus.sel, m_sel[0]);
        end
        step();
        n_tests++;
        if (bus.busy !== 1'b0 || bus.idx !== 3'd0) begin
            n_fail++;
            $display("FAIL stop_holds_idle: got busy=%b idx=%0d, expected busy=0 idx=0", bus.busy, bus.idx);
        end
        do_start(2, 1'b0);
        step();
        sb.push_back('{sel: m_sel[0], idx: 3'd0});
        pop_compare("write_while_busy_dropped");
        bus.period_done = 1'b1;
        step();
        bus.period_done = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b1 || bus.idx !== 3'd0) begin
            n_fail++;
            $display("FAIL dwell_kept_after_drop: got busy=%b idx=%0d, expected busy=1 idx=0", bus.busy, bus.idx);
        end
        do_stop();
    endtask

    task automatic test_full_table();
        for (int i = 0; i < 8; i++) write_entry(i, (i + 2) % 8, 1, 1'b0);
        do_start(0, 1'b0);
        step();
        sb.push_back('{sel: m_sel[0], idx: 3'd0});
        for (int i = 0; i < 8; i++) begin
            pop_compare("full_entry");
            bus.period_done = 1'b1;
            if (i < 7) sb.push_back('{sel: m_sel[i + 1], idx: 3'(i + 1)});
            step();
            bus.period_done = 1'b0;
            if (i < 7) step();
        end
        n_tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.idx !== 3'd7 || bus.tick !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_wrap: got done=%b busy=%b idx=%0d tick=%b, expected 1 0 7 0",
                     bus.done, bus.busy, bus.idx, bus.tick);
        end
        do_start(0, 1'b0);
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_from_done: got done=%b busy=%b, expected done=0 busy=1", bus.done, bus.busy);
        end
        step();
        sb.push_back('{sel: m_sel[0], idx: 3'd0});
        pop_compare("restart_entry0");
        do_stop();
    endtask

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_sel = '0; bus.cfg_dwell = '0;
        bus.cfg_last = 1'b0; bus.divisor = '0; bus.loop_en = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.period_done = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_loop();
        test_div0();
        test_stop_priority();
        test_full_table();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/waveform_sequencer.md
Name: waveform_sequencer

Overview:
- Playlist controller for the waveform generator datapath.
- Holds a small table of (waveform select, dwell) entries and steps through it.
- Drives the generator's 3-bit `sel` and a prescaled phase-advance strobe `tick` for the generator's counter enable.
- Counts completed waveform periods, using the counter's carry-out, to decide when to move to the next entry.

Parameters:
- DEPTH, 8, number of playlist entries; power of two, index width IW = log2(DEPTH).
- DWELL_W, 8, width of per-entry dwell count, in waveform periods.
- DIV_W, 8, width of prescaler divisor.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, released synchronously by design).
- cfg_we  input  1  table write strobe; honoured only when busy=0.
- cfg_addr  input  IW  table entry to write.
- cfg_sel  input  3  waveform select stored in entry.
- cfg_dwell  input  DWELL_W  periods to play entry; 0 treated as 1.
- cfg_last  input  1  marks entry as end of playlist.
- divisor  input  DIV_W  prescaler terminal value; sampled on start.
- loop_en  input  1  1 = restart at entry 0 after last entry; sampled on start.
- start  input  1  one-cycle pulse: begin playback at entry 0.
- stop  input  1  one-cycle pulse: abort playback.
- period_done  input  1  one-cycle pulse from generator counter carry-out (end of one waveform period).
- sel  output  3  waveform select to generator.
- tick  output  1  one-cycle phase-advance strobe (generator counter enable).
- busy  output  1  high in LOAD and RUN.
- done  output  1  high while in DONE.
- idx  output  IW  current playlist index.

Behaviour:
- Reset (rst=0):
  - State IDLE; sel=0, tick=0, busy=0, done=0, idx=0.
  - Prescaler=0, remaining=0, latched divisor=0, latched loop=0.
  - All table entries cleared (sel=0, dwell=0, last=0).
- Table write: when cfg_we=1 and busy=0, entry[cfg_addr] is updated at the clock edge. A write while busy=1 is dropped and the table is unchanged.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - On start=1 (and stop=0): latch divisor and loop_en, set idx=0, go to LOAD.
  - sel holds its last value.
- LOAD (exactly 1 cycle, busy=1, tick=0):
  - sel <= entry[idx].sel.
  - remaining <= (dwell==0 ? 1 : dwell).
  - Prescaler <= 0.
  - Next state RUN.
- RUN (busy=1):
  - Prescaler increments each cycle.
  - When prescaler == latched divisor: tick=1 for that cycle and prescaler <= 0. With divisor=0, tick=1 every RUN cycle.
  - On period_done=1:
    - If remaining>1: remaining decrements.
    - If remaining==1: advance.
  - Advance:
    - If entry[idx].last=1 or idx==DEPTH-1: with loop=1, idx <= 0 and go to LOAD; with loop=0, go to DONE.
    - Otherwise idx <= idx+1 and go to LOAD.
  - period_done in any state other than RUN is ignored.
- DONE:
  - done=1, busy=0, tick=0; sel and idx hold.
  - On start: same as from IDLE (done drops the next cycle).
- stop=1 in any state: next state IDLE, busy=0, done=0, tick=0 the next cycle; sel and idx hold.
  - stop has priority over start, period_done and advance in the same cycle.
- start while busy=1 restarts: latch inputs, idx=0, go to LOAD.
- Latency: start to first valid sel is 2 edges (IDLE→LOAD→RUN); sel is valid in the first RUN cycle. First tick comes divisor+1 RUN cycles later.
- Reset asserted mid-playback returns everything to reset values immediately, including the table.
- tick is registered; it is never high in IDLE, LOAD or DONE.

Test Plan:
1. Reset with rst=0 mid-RUN → sel=0, tick=0, busy=0, idx=0 asynchronously. After release, start with an empty table → entry0 dwell 0 treated as 1: a single period_done sends the FSM to advance.
2. Write entries {0: sel=1, dwell=2}, {1: sel=3, dwell=1, last=1}; divisor=3, loop_en=0; start.
   - sel=1 in the first RUN cycle; tick every 4th cycle.
   - 2 period_done pulses → LOAD, then sel=3, idx=1.
   - 1 more pulse → done=1, busy=0, tick stays 0.
3. Same table with loop_en=1 → after entry1 completes, idx=0 and sel=1 again; playback runs continuously for ≥3 loops.
4. divisor=0 → tick=1 on every RUN cycle, 0 on LOAD cycles.
5. stop and period_done in the same cycle during RUN → IDLE next cycle, idx unchanged, no advance. A cfg_we issued while busy leaves the table unchanged, checked after stop.
6. All 8 entries with last=0, loop_en=0 → after idx=7 completes, FSM goes to DONE (no wrap). A start in DONE restarts at idx=0 with done dropping after 1 cycle.
